// File: rtl/player_plot_sequencer_if.sv
// Plot-request bundle between the movement logic (master) and the plot sequencer (slave).
// The sequencer's plot side feeds the vga_adapter plot port.
interface player_plot_sequencer_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOUR_W    = 3
);
    logic                                enable;
    logic                                update;
    logic [NUM_PLAYERS-1:0]              active;
    logic [NUM_PLAYERS*(X_W+Y_W)-1:0]    pos;
    logic [NUM_PLAYERS*COLOUR_W-1:0]     colours;
    logic [X_W-1:0]                      x;
    logic [Y_W-1:0]                      y;
    logic [COLOUR_W-1:0]                 colour;
    logic                                plot;
    logic                                busy;
    logic                                frame_done;
    logic [NUM_PLAYERS-1:0]              collision;

    modport master (
        output enable, update, active, pos, colours,
        input  x, y, colour, plot, busy, frame_done, collision
    );

    modport slave (
        input  enable, update, active, pos, colours,
        output x, y, colour, plot, busy, frame_done, collision
    );
endinterface

// File: rtl/player_plot_sequencer.sv
// Snapshots player positions on each movement tick and walks them in index order,
// issuing one plot request per eligible player and reporting same-cell collisions.
module player_plot_sequencer #(
    parameter int NUM_PLAYERS    = 4,
    parameter int X_W            = 8,
    parameter int Y_W            = 7,
    parameter int COLOUR_W       = 3,
    parameter int SKIP_UNCHANGED = 0
) (
    input  logic CLOCK_50,
    input  logic resetn,
    player_plot_sequencer_if.slave bus
);
    localparam int PW    = X_W + Y_W;
    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [IDX_W-1:0]       idx_r;
    logic                   pending_r;
    logic [PW-1:0]          snap_pos_r    [NUM_PLAYERS];
    logic [COLOUR_W-1:0]    snap_colour_r [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] snap_active_r;
    logic [PW-1:0]          last_pos_r    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] last_valid_r;

    logic [X_W-1:0]         x_r;
    logic [Y_W-1:0]         y_r;
    logic [COLOUR_W-1:0]    colour_r;
    logic                   plot_r;
    logic                   busy_r;
    logic                   frame_done_r;
    logic [NUM_PLAYERS-1:0] collision_r;

    logic                   last_idx_s;
    logic                   take_snap_s;
    logic                   eligible_s;
    logic [NUM_PLAYERS-1:0] collision_s;

    assign last_idx_s = (idx_r == IDX_W'(NUM_PLAYERS - 1));

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE chains straight into a new sweep when work is queued
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.update && bus.enable) state_s = SCAN;
                else                          state_s = IDLE;
            end
            SCAN: begin
                if (last_idx_s) state_s = DONE;
                else            state_s = SCAN;
            end
            DONE: begin
                if (pending_r || bus.update) state_s = SCAN;
                else                         state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output decode: snapshot strobe, per-player eligibility, collision map
    always_comb begin
        take_snap_s = 1'b0;
        eligible_s  = 1'b0;
        collision_s = '0;
        case (state_r)
            IDLE: take_snap_s = bus.update && bus.enable;
            DONE: take_snap_s = pending_r || bus.update;
            SCAN: begin
                if (SKIP_UNCHANGED != 0) begin
                    eligible_s = snap_active_r[idx_r] &&
                                 !(last_valid_r[idx_r] && (last_pos_r[idx_r] == snap_pos_r[idx_r]));
                end else begin
                    eligible_s = snap_active_r[idx_r];
                end
            end
            default: take_snap_s = 1'b0;
        endcase
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                collision_s[i] = collision_s[i] |
                    ((j != i) && snap_active_r[i] && snap_active_r[j] &&
                     (snap_pos_r[j] == snap_pos_r[i]));
            end
        end
    end

    // Sweep datapath: snapshot, index, coalescing flag, last-plotted memory
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            idx_r         <= '0;
            pending_r     <= 1'b0;
            snap_active_r <= '0;
            last_valid_r  <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                snap_pos_r[i]    <= '0;
                snap_colour_r[i] <= '0;
                last_pos_r[i]    <= '0;
            end
        end else begin
            if (take_snap_s) begin
                idx_r         <= '0;
                snap_active_r <= bus.active;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    snap_pos_r[i]    <= bus.pos[i*PW +: PW];
                    snap_colour_r[i] <= bus.colours[i*COLOUR_W +: COLOUR_W];
                end
            end else if (state_r == SCAN) begin
                idx_r <= last_idx_s ? '0 : idx_r + 1'b1;
            end
            if (state_r == SCAN && bus.update) begin
                pending_r <= 1'b1;
            end else if (state_r == DONE) begin
                pending_r <= 1'b0;
            end
            if (eligible_s && (SKIP_UNCHANGED != 0)) begin
                last_pos_r[idx_r]   <= snap_pos_r[idx_r];
                last_valid_r[idx_r] <= 1'b1;
            end
        end
    end

    // Registered plot-port outputs
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            x_r          <= '0;
            y_r          <= '0;
            colour_r     <= '0;
            plot_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            collision_r  <= '0;
        end else begin
            plot_r       <= eligible_s;
            busy_r       <= (state_s != IDLE);
            frame_done_r <= (state_r == DONE);
            if (eligible_s) begin
                x_r      <= snap_pos_r[idx_r][PW-1:Y_W];
                y_r      <= snap_pos_r[idx_r][Y_W-1:0];
                colour_r <= snap_colour_r[idx_r];
            end
            if (state_r == DONE) begin
                collision_r <= collision_s;
            end
        end
    end

    assign bus.x          = x_r;
    assign bus.y          = y_r;
    assign bus.colour     = colour_r;
    assign bus.plot       = plot_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
    assign bus.collision  = collision_r;
endmodule

// File: tb/tb_player_plot_sequencer.sv
// Bench for player_plot_sequencer: one instance with SKIP_UNCHANGED=0 and one with 1 share
// the stimulus; a sweep-schedule reference model predicts every output on every cycle.
module tb_player_plot_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic resetn;
    logic enable;
    logic update;
    logic [N-1:0] active;
    logic [7:0] px [N];
    logic [6:0] py [N];
    logic [2:0] pc [N];
    logic [N*15-1:0] pos_v;
    logic [N*3-1:0]  col_v;

    int cyc = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int fd_cnt0 = 0;
    int plot_cnt1 = 0;

    // reference model state, indexed by instance (0: no skip, 1: skip unchanged)
    bit in_sw [2];
    int start [2];
    bit pend  [2];
    int sx [2][N];
    int sy [2][N];
    int scol [2][N];
    bit sact [2][N];
    int lx [2][N];
    int ly [2][N];
    bit lval [2][N];
    int ex [2];
    int ey [2];
    int ecol [2];
    int eplot [2];
    int ebusy [2];
    int efd [2];
    int ecoll [2];

    player_plot_sequencer_if #(.NUM_PLAYERS(N)) bus0 ();
    player_plot_sequencer_if #(.NUM_PLAYERS(N)) bus1 ();

    always_comb begin
        pos_v = '0;
        col_v = '0;
        for (int i = 0; i < N; i++) begin
            pos_v[i*15 +: 15] = {px[i], py[i]};
            col_v[i*3 +: 3]   = pc[i];
        end
    end

    assign bus0.enable  = enable;
    assign bus0.update  = update;
    assign bus0.active  = active;
    assign bus0.pos     = pos_v;
    assign bus0.colours = col_v;
    assign bus1.enable  = enable;
    assign bus1.update  = update;
    assign bus1.active  = active;
    assign bus1.pos     = pos_v;
    assign bus1.colours = col_v;

    player_plot_sequencer #(.NUM_PLAYERS(N), .SKIP_UNCHANGED(0)) dut0 (
        .CLOCK_50(clk), .resetn(resetn), .bus(bus0)
    );
    player_plot_sequencer #(.NUM_PLAYERS(N), .SKIP_UNCHANGED(1)) dut1 (
        .CLOCK_50(clk), .resetn(resetn), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic take_snapshot(input int v);
        for (int i = 0; i < N; i++) begin
            sx[v][i]   = int'(px[i]);
            sy[v][i]   = int'(py[i]);
            scol[v][i] = int'(pc[i]);
            sact[v][i] = active[i];
        end
        start[v] = cyc;
    endtask

    // Advance the model one rising edge: position within a sweep is cyc - start.
    task automatic model_step();
        for (int v = 0; v < 2; v++) begin
            if (!resetn) begin
                in_sw[v] = 1'b0; pend[v] = 1'b0;
                ex[v] = 0; ey[v] = 0; ecol[v] = 0; eplot[v] = 0;
                ebusy[v] = 0; efd[v] = 0; ecoll[v] = 0;
                for (int i = 0; i < N; i++) lval[v][i] = 1'b0;
            end else begin
                int ph;
                ph = cyc - start[v];
                eplot[v] = 0;
                efd[v] = 0;
                if (in_sw[v] && ph >= 1 && ph <= N) begin
                    int k;
                    bit elig;
                    k = ph - 1;
                    elig = sact[v][k];
                    if (v == 1 && lval[v][k] && lx[v][k] == sx[v][k] && ly[v][k] == sy[v][k])
                        elig = 1'b0;
                    if (elig) begin
                        eplot[v] = 1; ex[v] = sx[v][k]; ey[v] = sy[v][k]; ecol[v] = scol[v][k];
                        if (v == 1) begin
                            lx[v][k] = sx[v][k]; ly[v][k] = sy[v][k]; lval[v][k] = 1'b1;
                        end
                    end
                    if (update) pend[v] = 1'b1;
                end else if (in_sw[v]) begin
                    efd[v] = 1;
                    ecoll[v] = 0;
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++)
                            if (i != j && sact[v][i] && sact[v][j] &&
                                sx[v][i] == sx[v][j] && sy[v][i] == sy[v][j])
                                ecoll[v] = ecoll[v] | (1 << i);
                    if (pend[v] || update) begin
                        take_snapshot(v);
                        pend[v] = 1'b0;
                    end else begin
                        in_sw[v] = 1'b0;
                    end
                end else if (update && enable) begin
                    in_sw[v] = 1'b1;
                    take_snapshot(v);
                end
                ebusy[v] = in_sw[v] ? 1 : 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check("x0", 64'(bus0.x), 64'(ex[0]));
        check("y0", 64'(bus0.y), 64'(ey[0]));
        check("colour0", 64'(bus0.colour), 64'(ecol[0]));
        check("plot0", 64'(bus0.plot), 64'(eplot[0]));
        check("busy0", 64'(bus0.busy), 64'(ebusy[0]));
        check("frame_done0", 64'(bus0.frame_done), 64'(efd[0]));
        check("collision0", 64'(bus0.collision), 64'(ecoll[0]));
        check("x1", 64'(bus1.x), 64'(ex[1]));
        check("y1", 64'(bus1.y), 64'(ey[1]));
        check("colour1", 64'(bus1.colour), 64'(ecol[1]));
        check("plot1", 64'(bus1.plot), 64'(eplot[1]));
        check("busy1", 64'(bus1.busy), 64'(ebusy[1]));
        check("frame_done1", 64'(bus1.frame_done), 64'(efd[1]));
        check("collision1", 64'(bus1.collision), 64'(ecoll[1]));
        if (bus0.frame_done === 1'b1) fd_cnt0++;
        if (bus1.plot === 1'b1) plot_cnt1++;
    endtask

    task automatic sweep();
        update = 1'b1;
        tick();
        update = 1'b0;
        repeat (N + 2) tick();
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b0; update = 1'b0; active = '0;
        for (int i = 0; i < N; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end
        @(negedge clk);
        repeat (2) tick();
        resetn = 1'b1;
        tick();

        // basic sweep
        px[0] = 8'd10; py[0] = 7'd20; pc[0] = 3'd1;
        px[1] = 8'd30; py[1] = 7'd40; pc[1] = 3'd2;
        px[2] = 8'd50; py[2] = 7'd60; pc[2] = 3'd4;
        px[3] = 8'd70; py[3] = 7'd80; pc[3] = 3'd6;
        active = 4'b1111; enable = 1'b1;
        sweep();

        // inactive players skipped
        active = 4'b0101;
        sweep();

        // identical positions: skip instance plots nothing
        active = 4'b1111;
        plot_cnt1 = 0;
        sweep();
        check("unchanged_plots", 64'(plot_cnt1), 64'd0);

        // only player 3 moved
        py[3] = 7'd81;
        plot_cnt1 = 0;
        sweep();
        check("moved_plots", 64'(plot_cnt1), 64'd1);

        // collision between players 1 and 3
        px[1] = 8'd5; py[1] = 7'd5; px[3] = 8'd5; py[3] = 7'd5;
        update = 1'b1; tick(); update = 1'b0;
        repeat (N + 1) tick();
        check("collision_1010", 64'(bus0.collision), 64'h0000_0000_0000_000a);
        tick();
        active = 4'b0111;
        update = 1'b1; tick(); update = 1'b0;
        repeat (N + 1) tick();
        check("collision_none", 64'(bus0.collision), 64'd0);
        tick();

        // coalescing: two updates mid-sweep give one follow-on sweep
        active = 4'b1111;
        fd_cnt0 = 0;
        update = 1'b1; tick(); update = 1'b0;
        tick();
        update = 1'b1; tick(); update = 1'b0;
        tick();
        update = 1'b1; tick(); update = 1'b0;
        repeat (14) tick();
        check("coalesced_frames", 64'(fd_cnt0), 64'd2);

        // reset mid-sweep at idx 2
        update = 1'b1; tick(); update = 1'b0;
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        check("reset_plot", 64'(bus0.plot), 64'd0);
        check("reset_busy", 64'(bus0.busy), 64'd0);
        resetn = 1'b1;
        repeat (N + 2) tick();

        // randomized traffic over a small grid to provoke collisions and repeats
        for (int n = 0; n < 400; n++) begin
            resetn = ($urandom_range(99) != 0);
            update = ($urandom_range(3) == 0);
            enable = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) active = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) begin
                    px[i] = 8'($urandom_range(3));
                    py[i] = 7'($urandom_range(3));
                    pc[i] = 3'($urandom);
                end
            end
            tick();
        end
        update = 1'b0; resetn = 1'b1;
        repeat (2 * N + 4) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
